udma_qspi_cs_ctrl: RTL and testbench
====================================

UDMA_QSPI_CS_CTRL -- requirements
Module: udma_qspi_cs_ctrl

Interface
REQ-001 SHALL have parameter NUM_CS, default 4, meaning number of chip selects (1..8).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the setup/hold/gap timing counters.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: periph_clk_i and rst_i.
REQ-004 periph_clk_i  in  1  block clock; all state on its rising edge.
REQ-005 rst_i  in  1  asynchronous active-high reset.
REQ-006 cfg_setup_i / cfg_hold_i / cfg_gap_i  in  CNT_W each  CS-to-start, end-to-CS-release and minimum-deasserted cycle counts.
REQ-007 req_valid_i  in  1; req_ready_o  out  1  transfer request handshake.
REQ-008 req_cs_i  in  $clog2(NUM_CS) (min 1)  target chip select; req_mode_i  in  2  0 single, 1 dual, 2/3 quad.
REQ-009 req_dir_i  in  1  1 = TX (drive lanes), 0 = RX; req_keep_i  in  1  keep CS asserted after transfer.
REQ-010 xfer_start_o  out  1  one-cycle start pulse to the shifter; xfer_done_i  in  1  shifter completion pulse.
REQ-011 abort_i  in  1  synchronous abort.
REQ-012 csn_o  out  NUM_CS  active-low chip selects; sd_oe_o  out  4  active-high pad output enables, lanes 0..3.
REQ-013 busy_o  out  1  state != IDLE; eot_o  out  1  one-cycle end-of-transfer pulse.

Function
REQ-014 States: IDLE, SETUP, XFER, HOLD, GAP; counter cnt (CNT_W bits) counts down.
REQ-015 req_ready_o SHALL be 1 only in IDLE; a request is accepted when req_valid_i and req_ready_o are both 1; cs/mode/dir/keep are registered on acceptance.
REQ-016 Accept with no CS held: next cycle csn_o[cs]=0, state SETUP, cnt=cfg_setup_i; when cfg_setup_i=0, go directly to XFER.
REQ-017 SETUP: decrement each cycle; at cnt==1, go to XFER on the following cycle (exactly cfg_setup_i cycles in SETUP).
REQ-018 XFER: xfer_start_o=1 in the first XFER cycle only; xfer_done_i is ignored in that cycle and sampled from the next cycle onward.
REQ-019 xfer_done_i with keep=0: go to HOLD, cnt=cfg_hold_i (0 skips HOLD); CS stays low through HOLD.
REQ-020 HOLD exit: csn_o all 1, eot_o=1 in the same cycle, state GAP, cnt=cfg_gap_i; GAP lasts max(cfg_gap_i,1) cycles, then IDLE.
REQ-021 xfer_done_i with keep=1: eot_o=1 the cycle after done, state IDLE, CS stays held, held index remembered.
REQ-022 Accept while CS held with the same cs: skip SETUP, go directly to XFER.
REQ-023 Accept while CS held with a different cs: release the old CS on the next cycle, run GAP, then SETUP on the new cs (pending request retained).
REQ-024 sd_oe_o SHALL be 0 outside XFER; in XFER: single → 4'b0001 regardless of dir; dual TX → 4'b0011; quad TX → 4'b1111; dual/quad RX → 4'b0000.
REQ-025 abort_i (any state, priority over xfer_done_i): next cycle csn_o all 1, sd_oe_o=0, no eot_o, held CS and any pending request dropped, state GAP with cnt=cfg_gap_i.
REQ-026 abort_i in IDLE with no CS held SHALL have no effect.
REQ-027 At most one csn_o bit SHALL be low at any time.
REQ-028 cfg_* inputs are sampled only when loading cnt; changing them mid-phase does not affect the current phase.

Reset
REQ-029 Reset values: state IDLE, csn_o all 1, sd_oe_o 0, xfer_start_o 0, eot_o 0, busy_o 0, no CS held, cnt 0; req_ready_o 1 after reset release.
REQ-030 Reset mid-transfer SHALL release CS asynchronously without generating eot_o.

Verification
REQ-031 setup=2, hold=3, gap=4, cs=1, quad TX, done 5 cycles after start -> csn_o[1] low for 2+6+3 cycles, sd_oe_o=1111 during XFER only, eot_o at release, ready after 4 GAP cycles.
REQ-032 setup=hold=gap=0, single RX -> SETUP and HOLD skipped, sd_oe_o=0001 in XFER, GAP exactly 1 cycle.
REQ-033 keep=1 on cs=2, then same-cs request -> csn_o[2] continuously low, second xfer_start_o without SETUP, two eot_o pulses.
REQ-034 keep=1 on cs=0, then request on cs=3 -> csn_o[0] high for gap cycles before csn_o[3] goes low; never both low.
REQ-035 abort_i asserted in the same cycle as xfer_done_i, in XFER -> no eot_o, CS released next cycle, GAP entered.
REQ-036 rst_i pulsed during HOLD -> csn_o all 1 immediately, eot_o never asserts, req_ready_o=1 after release.

Source files
------------

// File: rtl/udma_qspi_cs_ctrl.sv
// QSPI chip-select sequencer: CS setup, transfer handshake to the shifter,
// CS hold, minimum deasserted gap, optional CS keep between transfers, abort.
module udma_qspi_cs_ctrl #(
    parameter int NUM_CS = 4,
    parameter int CNT_W  = 8,
    localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              periph_clk_i,
    input  logic              rst_i,
    input  logic [CNT_W-1:0]  cfg_setup_i,
    input  logic [CNT_W-1:0]  cfg_hold_i,
    input  logic [CNT_W-1:0]  cfg_gap_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [CS_W-1:0]   req_cs_i,
    input  logic [1:0]        req_mode_i,
    input  logic              req_dir_i,
    input  logic              req_keep_i,
    output logic              xfer_start_o,
    input  logic              xfer_done_i,
    input  logic              abort_i,
    output logic [NUM_CS-1:0] csn_o,
    output logic [3:0]        sd_oe_o,
    output logic              busy_o,
    output logic              eot_o
);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CS_W-1:0]  cs_q, cs_d;
    logic [1:0]       mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             keep_q, keep_d;
    logic             held_q, held_d;
    logic             pend_q, pend_d;
    logic             first_q, first_d;
    logic             eot_q, eot_d;
    logic             cs_active;

    always_ff @(posedge periph_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cs_q    <= '0;
            mode_q  <= '0;
            dir_q   <= 1'b0;
            keep_q  <= 1'b0;
            held_q  <= 1'b0;
            pend_q  <= 1'b0;
            first_q <= 1'b0;
            eot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            keep_q  <= keep_d;
            held_q  <= held_d;
            pend_q  <= pend_d;
            first_q <= first_d;
            eot_q   <= eot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cs_d    = cs_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        keep_d  = keep_q;
        held_d  = held_q;
        pend_d  = pend_q;
        first_d = 1'b0;
        eot_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    cs_d   = req_cs_i;
                    mode_d = req_mode_i;
                    dir_d  = req_dir_i;
                    keep_d = req_keep_i;
                    held_d = 1'b0;
                    if (held_q && (req_cs_i == cs_q)) begin
                        state_d = XFER;
                        first_d = 1'b1;
                    end else if (held_q) begin
                        // Different target: release old CS first, request waits in GAP
                        state_d = GAP;
                        cnt_d   = cfg_gap_i;
                        pend_d  = 1'b1;
                    end else if (cfg_setup_i == '0) begin
                        state_d = XFER;
                        first_d = 1'b1;
                    end else begin
                        state_d = SETUP;
                        cnt_d   = cfg_setup_i;
                    end
                end
            end
            SETUP: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = XFER;
                    first_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            XFER: begin
                if (!first_q && xfer_done_i) begin
                    if (keep_q) begin
                        state_d = IDLE;
                        held_d  = 1'b1;
                        eot_d   = 1'b1;
                    end else if (cfg_hold_i == '0) begin
                        state_d = GAP;
                        cnt_d   = cfg_gap_i;
                        eot_d   = 1'b1;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = cfg_hold_i;
                    end
                end
            end
            HOLD: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = GAP;
                    cnt_d   = cfg_gap_i;
                    eot_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q <= CNT_W'(1)) begin
                    pend_d = 1'b0;
                    if (!pend_q) begin
                        state_d = IDLE;
                    end else if (cfg_setup_i == '0) begin
                        state_d = XFER;
                        first_d = 1'b1;
                    end else begin
                        state_d = SETUP;
                        cnt_d   = cfg_setup_i;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides everything above, except in IDLE with nothing held
        if (abort_i && ((state_q != IDLE) || held_q)) begin
            state_d = GAP;
            cnt_d   = cfg_gap_i;
            held_d  = 1'b0;
            pend_d  = 1'b0;
            first_d = 1'b0;
            eot_d   = 1'b0;
        end
    end

    assign cs_active = (state_q == SETUP) || (state_q == XFER) || (state_q == HOLD) ||
                       ((state_q == IDLE) && held_q);

    always_comb begin
        csn_o = '1;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (cs_active && (cs_q == CS_W'(i))) csn_o[i] = 1'b0;
        end
    end

    always_comb begin
        sd_oe_o = '0;
        if (state_q == XFER) begin
            case (mode_q)
                2'd0:    sd_oe_o = 4'b0001;
                2'd1:    sd_oe_o = dir_q ? 4'b0011 : 4'b0000;
                default: sd_oe_o = dir_q ? 4'b1111 : 4'b0000;
            endcase
        end
    end

    assign xfer_start_o = (state_q == XFER) && first_q;
    assign req_ready_o  = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign eot_o        = eot_q;

endmodule

// File: tb/tb_udma_qspi_cs_ctrl.sv
// Self-checking bench: each transfer is expanded into a per-cycle expected
// output schedule from the phase lengths, then compared against the DUT.
module tb_udma_qspi_cs_ctrl;

    localparam int NUM_CS = 4;
    localparam int CNT_W  = 8;
    localparam int CS_W   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CNT_W-1:0]  cfg_setup_i = '0, cfg_hold_i = '0, cfg_gap_i = '0;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    logic [CS_W-1:0]   req_cs_i = '0;
    logic [1:0]        req_mode_i = '0;
    logic              req_dir_i = 1'b0, req_keep_i = 1'b0;
    logic              xfer_start_o;
    logic              xfer_done_i = 1'b0, abort_i = 1'b0;
    logic [NUM_CS-1:0] csn_o;
    logic [3:0]        sd_oe_o;
    logic              busy_o, eot_o;

    always #5 clk = ~clk;

    udma_qspi_cs_ctrl #(.NUM_CS(NUM_CS), .CNT_W(CNT_W)) dut (
        .periph_clk_i(clk), .rst_i(rst),
        .cfg_setup_i(cfg_setup_i), .cfg_hold_i(cfg_hold_i), .cfg_gap_i(cfg_gap_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_cs_i(req_cs_i),
        .req_mode_i(req_mode_i), .req_dir_i(req_dir_i), .req_keep_i(req_keep_i),
        .xfer_start_o(xfer_start_o), .xfer_done_i(xfer_done_i), .abort_i(abort_i),
        .csn_o(csn_o), .sd_oe_o(sd_oe_o), .busy_o(busy_o), .eot_o(eot_o)
    );

    typedef struct {
        logic [NUM_CS-1:0] csn;
        logic [3:0]        oe;
        bit st, eot, busy, ready, valid, done, abort, load;
    } ent_t;

    ent_t exp_q[$];
    ent_t ce;
    int   checks = 0, errors = 0;
    int   n_low[NUM_CS];
    int   n_oe_f, n_oe_1, n_start, n_eot;

    // model state between transfers
    int   held = -1;
    bit   pend_eot = 1'b0;
    logic [CS_W-1:0]  t_cs;
    logic [1:0]       t_mode;
    logic             t_dir, t_keep;
    logic [CNT_W-1:0] t_s, t_h, t_g;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clr();
        foreach (n_low[i]) n_low[i] = 0;
        n_oe_f = 0; n_oe_1 = 0; n_start = 0; n_eot = 0;
    endtask

    function automatic ent_t mk(int low, logic [3:0] oe, bit st, bit eot, bit busy);
        ent_t e;
        e.csn = '1;
        if (low >= 0) e.csn[low] = 1'b0;
        e.oe = oe; e.st = st; e.eot = eot; e.busy = busy; e.ready = !busy;
        e.valid = 0; e.done = 0; e.abort = 0; e.load = 0;
        return e;
    endfunction

    function automatic logic [3:0] oe_of(int m, bit d);
        if (m == 0) return 4'b0001;
        if (m == 1) return d ? 4'b0011 : 4'b0000;
        return d ? 4'b1111 : 4'b0000;
    endfunction

    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            chk("csn", int'(csn_o), int'(ce.csn));
            chk("sd_oe", int'(sd_oe_o), int'(ce.oe));
            chk("xfer_start", int'(xfer_start_o), int'(ce.st));
            chk("eot", int'(eot_o), int'(ce.eot));
            chk("busy", int'(busy_o), int'(ce.busy));
            chk("ready", int'(req_ready_o), int'(ce.ready));
            chk("one_cs_low", int'($countones(~csn_o) <= 1), 1);
            for (int i = 0; i < NUM_CS; i++) if (!csn_o[i]) n_low[i]++;
            if (sd_oe_o == 4'b1111) n_oe_f++;
            if (sd_oe_o == 4'b0001) n_oe_1++;
            if (xfer_start_o) n_start++;
            if (eot_o) n_eot++;
        end
    end

    // Config is only trusted on cycles where the DUT loads its counter
    task automatic drive(input ent_t e);
        @(posedge clk); #1;
        req_valid_i = e.valid; req_cs_i = t_cs; req_mode_i = t_mode;
        req_dir_i = t_dir; req_keep_i = t_keep;
        xfer_done_i = e.done; abort_i = e.abort;
        if (e.load) begin
            cfg_setup_i = t_s; cfg_hold_i = t_h; cfg_gap_i = t_g;
        end else begin
            cfg_setup_i = CNT_W'($urandom); cfg_hold_i = CNT_W'($urandom);
            cfg_gap_i = CNT_W'($urandom);
        end
        exp_q.push_back(e);
    endtask

    task automatic idle_cycle(input bit try_abort);
        ent_t e;
        int   g;
        e = mk(held, 4'b0, 0, pend_eot, 0);
        pend_eot = 0;
        e.abort = try_abort;
        if (try_abort && held >= 0) begin
            t_g = CNT_W'($urandom_range(0, 4));
            g = (t_g == 0) ? 1 : int'(t_g);
            e.load = 1;
            drive(e);
            held = -1;
            for (int i = 0; i < g; i++) drive(mk(-1, 4'b0, 0, 0, 1));
        end else begin
            drive(e);
        end
    endtask

    task automatic txn(input int cs, input int m, input bit d, input bit k,
                       input int s, input int h, input int g, input int dl,
                       input int ap, input bit dfirst, input int rst_at);
        ent_t q[$];
        ent_t e;
        int   gg;
        bit   same;
        t_cs = CS_W'(cs); t_mode = 2'(m); t_dir = d; t_keep = k;
        t_s = CNT_W'(s); t_h = CNT_W'(h); t_g = CNT_W'(g);
        gg = (g == 0) ? 1 : g;
        same = (held == cs);
        e = mk(held, 4'b0, 0, pend_eot, 0);
        e.valid = 1; e.load = 1;
        pend_eot = 0;
        q.push_back(e);
        if (held >= 0 && !same) begin
            for (int i = 0; i < gg; i++) begin
                e = mk(-1, 4'b0, 0, 0, 1);
                if (i == gg - 1) e.load = 1;
                q.push_back(e);
            end
        end
        if (!same) for (int i = 0; i < s; i++) q.push_back(mk(cs, 4'b0, 0, 0, 1));
        for (int i = 0; i <= dl; i++) begin
            e = mk(cs, oe_of(m, d), i == 0, 0, 1);
            if (i == 0 && dfirst) e.done = 1;
            if (i == dl) begin e.done = 1; e.load = 1; end
            q.push_back(e);
        end
        if (!k) begin
            for (int i = 0; i < h; i++) begin
                e = mk(cs, 4'b0, 0, 0, 1);
                if (i == h - 1) e.load = 1;
                q.push_back(e);
            end
            for (int i = 0; i < gg; i++) q.push_back(mk(-1, 4'b0, 0, i == 0, 1));
        end
        if (ap > 0 && ap < q.size()) begin
            while (q.size() > ap + 1) void'(q.pop_back());
            q[ap].abort = 1; q[ap].load = 1;
            for (int i = 0; i < gg; i++) q.push_back(mk(-1, 4'b0, 0, 0, 1));
            held = -1;
        end else begin
            held = k ? cs : -1;
            pend_eot = k;
        end
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            if (i == rst_at) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_csn", int'(csn_o), (1 << NUM_CS) - 1);
                chk("rst_eot", int'(eot_o), 0);
                chk("rst_busy", int'(busy_o), 0);
                chk("rst_oe", int'(sd_oe_o), 0);
                exp_q.delete();
                req_valid_i = 0; xfer_done_i = 0; abort_i = 0;
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                held = -1; pend_eot = 0;
                break;
            end
        end
    endtask

    task automatic settle();
        idle_cycle(0);
        idle_cycle(0);
        @(negedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        #3;
        chk("reset_csn", int'(csn_o), (1 << NUM_CS) - 1);
        chk("reset_oe", int'(sd_oe_o), 0);
        chk("reset_start", int'(xfer_start_o), 0);
        chk("reset_eot", int'(eot_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", int'(req_ready_o), 1);

        // setup=2 hold=3 gap=4, cs1 quad TX, done 5 cycles after start
        clr();
        txn(1, 2, 1, 0, 2, 3, 4, 5, 0, 0, -1);
        settle();
        chk("d1_cs1_low", n_low[1], 11);
        chk("d1_oe_quad", n_oe_f, 6);
        chk("d1_eot", n_eot, 1);
        chk("d1_start", n_start, 1);

        // all timings zero, single RX
        clr();
        txn(0, 0, 0, 0, 0, 0, 0, 3, 0, 1, -1);
        settle();
        chk("d2_cs0_low", n_low[0], 4);
        chk("d2_oe_single", n_oe_1, 4);

        // keep on cs2, then same-cs request
        clr();
        txn(2, 1, 1, 1, 1, 1, 1, 2, 0, 0, -1);
        txn(2, 2, 0, 0, 2, 1, 1, 2, 0, 0, -1);
        settle();
        chk("d3_start", n_start, 2);
        chk("d3_eot", n_eot, 2);
        chk("d3_cs2_low", n_low[2], 9);

        // keep on cs0, then switch to cs3
        clr();
        txn(0, 0, 1, 1, 1, 0, 3, 1, 0, 0, -1);
        txn(3, 0, 1, 0, 1, 0, 3, 1, 0, 0, -1);
        settle();
        chk("d4_cs0_low", n_low[0], 4);
        chk("d4_cs3_low", n_low[3], 3);

        // abort together with done
        clr();
        txn(1, 2, 1, 0, 1, 2, 2, 3, 5, 0, -1);
        settle();
        chk("d5_eot", n_eot, 0);
        chk("d5_cs1_low", n_low[1], 5);

        // reset pulse during HOLD
        clr();
        txn(2, 0, 1, 0, 1, 4, 2, 2, 0, 0, 6);
        settle();
        chk("d6_eot", n_eot, 0);
        chk("d6_ready", int'(req_ready_o), 1);

        for (int n = 0; n < 150; n++) begin
            txn($urandom_range(0, NUM_CS - 1), $urandom_range(0, 3), 1'($urandom),
                1'($urandom), $urandom_range(0, 5), $urandom_range(0, 5),
                $urandom_range(0, 5), $urandom_range(1, 6),
                ($urandom_range(0, 7) == 0) ? $urandom_range(1, 20) : 0,
                1'($urandom), -1);
            repeat ($urandom_range(0, 2)) idle_cycle($urandom_range(0, 5) == 0);
        end
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
